// File: rtl/counter_seq_pkg.sv
// Shared types and helpers for the counter sequencer: FSM state encoding,
// rate-select codes and the Speed-to-period mapping.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [1:0] SPEED_EVERY = 2'b00;
  localparam logic [1:0] SPEED_1X    = 2'b01;
  localparam logic [1:0] SPEED_2X    = 2'b10;
  localparam logic [1:0] SPEED_4X    = 2'b11;

  // Number of clock cycles between enable strobes for a given rate select.
  function automatic int period(input logic [1:0] speed, input int clock_hz);
    int result;
    case (speed)
      SPEED_EVERY: result = 1;
      SPEED_1X:    result = clock_hz;
      SPEED_2X:    result = 2 * clock_hz;
      default:     result = 4 * clock_hz;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rate_divider.sv
// Loadable down-counter that flags when it has reached zero; load wins over
// decrement and the count parks at zero rather than wrapping.
module rate_divider #(
  parameter int DIV_W = 28
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [DIV_W-1:0] load_value,
  input  logic             enable,
  output logic             terminal
);

  logic [DIV_W-1:0] count;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - DIV_W'(1);
    end
  end

  assign terminal = (count == '0);

endmodule

// File: rtl/counter_sequencer.sv
// Sequences an external enable-driven up-counter: rate-divided increment
// strobes, run/pause/done control and terminal-count wrap or one-shot halt.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int CLOCK_HZ = 50000000,
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 28
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Stop,
  input  logic             Clear,
  input  logic [1:0]       Speed,
  input  logic             Mode,
  input  logic [WIDTH-1:0] Limit,
  input  logic [WIDTH-1:0] CounterValue,
  output logic             CounterEnable,
  output logic             CounterClear,
  output logic             Running,
  output logic             Done
);

  state_t           state;
  state_t           next_state;
  logic [1:0]       speed_q;
  logic             running_q;
  logic             done_q;
  logic             speed_change;
  logic             at_limit;
  logic             tick;
  logic             div_terminal;
  logic             div_load;
  logic             div_enable;
  logic [DIV_W-1:0] reload_value;

  assign speed_change = (speed_q != Speed);
  assign at_limit     = (CounterValue == Limit);
  assign reload_value = DIV_W'(period(Speed, CLOCK_HZ) - 1);

  // Any command this cycle pre-empts the tick, so Stop and Clear never race an enable.
  assign tick = Reset && (state == RUN) && div_terminal && !speed_change && !Clear && !Stop;

  assign div_load   = Clear || ((state != RUN) && (next_state == RUN)) || tick || speed_change;
  assign div_enable = (state == RUN);

  rate_divider #(
    .DIV_W(DIV_W)
  ) u_rate_divider (
    .Clock     (Clock),
    .Reset     (Reset),
    .load      (div_load),
    .load_value(reload_value),
    .enable    (div_enable),
    .terminal  (div_terminal)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      speed_q   <= SPEED_EVERY;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= next_state;
      speed_q   <= Speed;
      running_q <= (next_state == RUN);
      done_q    <= (next_state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    if (Clear) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: if (Start && !Stop) next_state = RUN;
        RUN: begin
          if (Stop) next_state = PAUSE;
          else if (tick && at_limit && Mode) next_state = DONE;
        end
        DONE:    next_state = DONE;
        default: next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    CounterEnable = tick && !at_limit;
    CounterClear  = Reset && ((tick && at_limit && !Mode) || Clear);
  end

  assign Running = running_q;
  assign Done    = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with CLOCK_HZ=4 and a behavioural
// 8-bit counter closing the CounterValue feedback loop.
module tb_counter_sequencer;

  localparam int CLOCK_HZ = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, stop, clear;
  logic [1:0] speed;
  logic       mode;
  logic [7:0] limit;
  logic [7:0] counter_value = 8'd0;
  logic       counter_enable, counter_clear, running, done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       start;
    logic       stop;
    logic       clear;
    logic       mode;
    logic [7:0] limit;
    logic       en;
    logic       clr;
    logic       run;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  counter_sequencer #(
    .CLOCK_HZ(CLOCK_HZ),
    .WIDTH   (8),
    .DIV_W   (28)
  ) dut (
    .Clock        (clock),
    .Reset        (reset_n),
    .Start        (start),
    .Stop         (stop),
    .Clear        (clear),
    .Speed        (speed),
    .Mode         (mode),
    .Limit        (limit),
    .CounterValue (counter_value),
    .CounterEnable(counter_enable),
    .CounterClear (counter_clear),
    .Running      (running),
    .Done         (done)
  );

  // The external datapath being sequenced.
  always @(posedge clock) begin
    if (counter_clear) counter_value <= 8'd0;
    else if (counter_enable) counter_value <= counter_value + 8'd1;
  end

  task automatic applyStimulus(input logic s, input logic p, input logic c,
                               input logic [1:0] sp, input logic m, input logic [7:0] lim);
    @(negedge clock);
    start = s;
    stop  = p;
    clear = c;
    speed = sp;
    mode  = m;
    limit = lim;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  task automatic add(input logic s, input logic p, input logic c, input logic m,
                     input logic [7:0] lim, input logic en, input logic clr,
                     input logic run, input logic dn);
    vec_t v;
    v.start = s; v.stop = p; v.clear = c; v.mode = m; v.limit = lim;
    v.en = en; v.clr = clr; v.run = run; v.done = dn;
    vecs.push_back(v);
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0; stop = 1'b0; clear = 1'b1;
    speed = 2'b00; mode = 1'b0; limit = 8'd5;

    // Speed 00 vectors: start, stop, clear, mode, limit | en, clr, run, done
    add(1,0,0,0,5, 0,0,0,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(0,0,0,0,5, 0,1,1,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(0,1,0,0,5, 0,0,1,0);
    add(0,0,0,0,5, 0,0,0,0);
    add(0,0,1,0,5, 0,1,0,0);
    add(0,0,0,0,5, 0,0,0,0);
    add(1,0,0,1,3, 0,0,0,0);
    add(0,0,0,1,3, 1,0,1,0);
    add(0,0,0,1,3, 1,0,1,0);
    add(0,0,0,1,3, 1,0,1,0);
    add(0,0,0,1,3, 0,0,1,0);
    add(0,0,0,1,3, 0,0,0,1);
    add(1,0,0,1,3, 0,0,0,1);
    add(0,0,0,1,3, 0,0,0,1);
    add(0,0,1,1,3, 0,1,0,1);
    add(0,0,0,1,3, 0,0,0,0);
    add(1,0,0,1,0, 0,0,0,0);
    add(0,0,0,1,0, 0,0,1,0);
    add(0,0,0,1,0, 0,0,0,1);
    add(0,0,1,1,0, 0,1,0,1);
    add(0,0,0,1,0, 0,0,0,0);
    add(1,0,0,0,5, 0,0,0,0);
    add(0,0,0,0,5, 1,0,1,0);
    add(1,1,1,0,5, 0,1,1,0);
    add(0,0,0,0,5, 0,0,0,0);
    add(0,1,0,0,5, 0,0,0,0);
    add(0,0,0,0,5, 0,0,0,0);

    // Held in reset with Clear high: strobes and status stay low.
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("reset_en", counter_enable, 1'b0);
    checkOutput("reset_clr", counter_clear, 1'b0);
    checkOutput("reset_run", running, 1'b0);
    checkOutput("reset_done", done, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    clear   = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].clear, 2'b00, vecs[i].mode, vecs[i].limit);
      checkOutput($sformatf("vec%0d_en", i), counter_enable, vecs[i].en);
      checkOutput($sformatf("vec%0d_clr", i), counter_clear, vecs[i].clr);
      checkOutput($sformatf("vec%0d_run", i), running, vecs[i].run);
      checkOutput($sformatf("vec%0d_done", i), done, vecs[i].done);
    end

    // Speed 01: enable every 4 cycles, then a switch to 11 restarts a 16-cycle wait.
    applyStimulus(0, 0, 1, 2'b01, 0, 8'd200);
    checkOutput("spd_clear_clr", counter_clear, 1'b1);
    applyStimulus(1, 0, 0, 2'b01, 0, 8'd200);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0, 0, 2'b01, 0, 8'd200);
      checkOutput($sformatf("spd1x_k%0d_en", k), counter_enable, (k == 4) || (k == 8));
    end
    applyStimulus(0, 0, 0, 2'b11, 0, 8'd200);
    checkOutput("spd_change_en", counter_enable, 1'b0);
    for (int k = 10; k <= 25; k++) begin
      applyStimulus(0, 0, 0, 2'b11, 0, 8'd200);
      checkOutput($sformatf("spd4x_k%0d_en", k), counter_enable, k == 25);
    end

    // Stop with the divider at 2, then resume from a freshly reloaded divider.
    applyStimulus(0, 0, 1, 2'b01, 0, 8'd200);
    checkOutput("pause_clear_clr", counter_clear, 1'b1);
    applyStimulus(1, 0, 0, 2'b01, 0, 8'd200);
    applyStimulus(0, 0, 0, 2'b01, 0, 8'd200);
    checkOutput("pause_k1_run", running, 1'b1);
    applyStimulus(0, 1, 0, 2'b01, 0, 8'd200);
    checkOutput("pause_stop_en", counter_enable, 1'b0);
    checkOutput("pause_stop_run", running, 1'b1);
    for (int k = 3; k <= 5; k++) begin
      applyStimulus(0, 0, 0, 2'b01, 0, 8'd200);
      checkOutput($sformatf("pause_k%0d_en", k), counter_enable, 1'b0);
      checkOutput($sformatf("pause_k%0d_run", k), running, 1'b0);
    end
    applyStimulus(1, 0, 0, 2'b01, 0, 8'd200);
    checkOutput("resume_start_en", counter_enable, 1'b0);
    for (int k = 7; k <= 10; k++) begin
      applyStimulus(0, 0, 0, 2'b01, 0, 8'd200);
      checkOutput($sformatf("resume_k%0d_en", k), counter_enable, k == 10);
      checkOutput($sformatf("resume_k%0d_run", k), running, 1'b1);
    end

    // Asynchronous reset pulse between edges while running at full rate.
    applyStimulus(0, 0, 1, 2'b00, 0, 8'd200);
    applyStimulus(1, 0, 0, 2'b00, 0, 8'd200);
    applyStimulus(0, 0, 0, 2'b00, 0, 8'd200);
    checkOutput("areset_pre_en", counter_enable, 1'b1);
    applyStimulus(0, 0, 0, 2'b00, 0, 8'd200);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("areset_now_en", counter_enable, 1'b0);
    checkOutput("areset_now_run", running, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 2'b00, 0, 8'd200);
      checkOutput($sformatf("areset_idle%0d_en", k), counter_enable, 1'b0);
      checkOutput($sformatf("areset_idle%0d_run", k), running, 1'b0);
    end
    applyStimulus(1, 0, 0, 2'b00, 0, 8'd200);
    checkOutput("areset_start_en", counter_enable, 1'b0);
    applyStimulus(0, 0, 0, 2'b00, 0, 8'd200);
    checkOutput("areset_resume_en", counter_enable, 1'b1);
    checkOutput("areset_resume_run", running, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
